// File: rtl/uart_cmd_pkg.sv
// Shared types, character constants and the hex-digit decoder for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG2,
    ST_COLON,
    ST_SPACE,
    ST_ZERO,
    ST_XCHAR,
    ST_DIGITS
  } parser_state_t;

  typedef enum logic {
    CH_SW,
    CH_BT
  } channel_t;

  localparam logic [7:0] CHAR_S     = 8'h53;
  localparam logic [7:0] CHAR_W     = 8'h57;
  localparam logic [7:0] CHAR_B     = 8'h42;
  localparam logic [7:0] CHAR_T     = 8'h54;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_X_LO  = 8'h78;
  localparam logic [7:0] CHAR_X_UP  = 8'h58;

  // Returns {valid, nibble}; valid is 0 for anything outside 0-9, A-F, a-f.
  function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
    logic [4:0] r;
    r = 5'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      r = {1'b1, ch[3:0]};
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      r = {1'b1, ch[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter for the command parser; only instantiated when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  assign o_expired = i_run && (r_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clear || o_expired) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-serial parser for "SW: 0x<hex>" / "BT: 0x<hex>" commands from a UART receiver.
// Optional inter-byte timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int HEX_DIGITS     = 4,
  parameter int SWITCH_COUNT   = 16,
  parameter int BUTTON_COUNT   = 5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [SWITCH_COUNT-1:0] switch_data,
  output logic [BUTTON_COUNT-1:0] button_data,
  output logic                    switch_update,
  output logic                    button_update,
  output logic                    parse_error,
  output logic                    busy,
  output parser_state_t           dbg_state
);

  localparam int ACC_W  = HEX_DIGITS * 4;
  localparam int EXT_W0 = (ACC_W > SWITCH_COUNT) ? ACC_W : SWITCH_COUNT;
  localparam int EXT_W  = (EXT_W0 > BUTTON_COUNT) ? EXT_W0 : BUTTON_COUNT;
  localparam int CNT_W  = $clog2(HEX_DIGITS + 1);

  parser_state_t    r_state;
  channel_t         r_channel;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [7:0]       w_char;
  logic             w_take;
  logic [4:0]       w_hex;
  logic [ACC_W+3:0] w_shift;
  logic [ACC_W-1:0] w_acc_next;
  logic [EXT_W-1:0] w_ext;
  logic             w_last;
  logic             w_is_tag;
  channel_t         w_tag_ch;
  logic             w_match;
  logic             w_expired;
  logic             w_unused_rx;

  assign w_char      = 8'(rx_data);
  assign w_unused_rx = ^rx_data;
  assign w_take      = ena && rx_valid;
  assign w_hex       = hex_nibble(w_char);
  assign w_shift     = {r_acc, w_hex[3:0]};
  assign w_acc_next  = w_shift[ACC_W-1:0];
  assign w_ext       = EXT_W'(w_acc_next);
  assign w_last      = (r_cnt == CNT_W'(HEX_DIGITS - 1));
  assign w_is_tag    = (w_char == CHAR_S) || (w_char == CHAR_B);
  assign w_tag_ch    = (w_char == CHAR_B) ? CH_BT : CH_SW;

  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

  always_comb begin
    w_match = 1'b0;
    case (r_state)
      ST_TAG2:   w_match = (r_channel == CH_SW) ? (w_char == CHAR_W) : (w_char == CHAR_T);
      ST_COLON:  w_match = (w_char == CHAR_COLON);
      ST_SPACE:  w_match = (w_char == CHAR_SPACE);
      ST_ZERO:   w_match = (w_char == CHAR_ZERO);
      ST_XCHAR:  w_match = (w_char == CHAR_X_LO) || (w_char == CHAR_X_UP);
      ST_DIGITS: w_match = w_hex[4];
      default:   w_match = 1'b0;
    endcase
  end

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_run    (ena && busy),
    .i_clear  (w_take || !busy),
    .o_expired(w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_expired        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_channel     <= CH_SW;
      r_acc         <= '0;
      r_cnt         <= '0;
      switch_data   <= '0;
      button_data   <= '0;
      switch_update <= 1'b0;
      button_update <= 1'b0;
      parse_error   <= 1'b0;
    end else begin
      switch_update <= 1'b0;
      button_update <= 1'b0;
      parse_error   <= 1'b0;
      if (w_take) begin
        if (r_state == ST_IDLE) begin
          if (w_is_tag) begin
            r_state   <= ST_TAG2;
            r_channel <= w_tag_ch;
          end
        end else if (!w_match) begin
          // A stray 'S'/'B' is treated as the start of a fresh command.
          parse_error <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          if (w_is_tag) begin
            r_state   <= ST_TAG2;
            r_channel <= w_tag_ch;
          end else begin
            r_state <= ST_IDLE;
          end
        end else begin
          case (r_state)
            ST_TAG2:  r_state <= ST_COLON;
            ST_COLON: r_state <= ST_SPACE;
            ST_SPACE: r_state <= ST_ZERO;
            ST_ZERO:  r_state <= ST_XCHAR;
            ST_XCHAR: begin
              r_state <= ST_DIGITS;
              r_acc   <= '0;
              r_cnt   <= '0;
            end
            ST_DIGITS: begin
              if (w_last) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
                if (r_channel == CH_SW) begin
                  switch_data   <= w_ext[SWITCH_COUNT-1:0];
                  switch_update <= 1'b1;
                end else begin
                  button_data   <= w_ext[BUTTON_COUNT-1:0];
                  button_update <= 1'b1;
                end
              end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end else if (ena && w_expired) begin
        parse_error <= 1'b1;
        r_state     <= ST_IDLE;
        r_acc       <= '0;
        r_cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus randomized command streams
// compared cycle by cycle against a string-level reference model.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int HD = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ena;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [15:0]   switch_data;
  logic [4:0]    button_data;
  logic          switch_update;
  logic          button_update;
  logic          parse_error;
  logic          busy;
  parser_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_cmd_parser #(
    .DATA_WIDTH(8), .HEX_DIGITS(HD), .SWITCH_COUNT(16), .BUTTON_COUNT(5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .rx_data(rx_data), .rx_valid(rx_valid),
    .switch_data(switch_data), .button_data(button_data),
    .switch_update(switch_update), .button_update(button_update),
    .parse_error(parse_error), .busy(busy), .dbg_state(dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Holds the characters of the command received so far; commits when the full text is present.
  byte unsigned m_cmd[$];
  logic [15:0]  m_sw;
  logic [4:0]   m_bt;
  logic         m_swu, m_btu, m_err;
  int           m_idle;
  logic [16:0]  exp_q[$];   // {is_button, value}

  function automatic bit is_hex(byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hex_val(byte unsigned c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  function automatic bit char_fits(int pos, byte unsigned tag, byte unsigned c);
    case (pos)
      1:       return c == ((tag == "S") ? 8'h57 : 8'h54);
      2:       return c == ":";
      3:       return c == " ";
      4:       return c == "0";
      5:       return (c == "x") || (c == "X");
      default: return is_hex(c);
    endcase
  endfunction

  function automatic void model_reset();
    m_cmd.delete();
    m_sw = '0; m_bt = '0; m_swu = 0; m_btu = 0; m_err = 0; m_idle = 0;
  endfunction

  function automatic void model_step(bit e, bit v, byte unsigned d);
    longint unsigned value;
    m_swu = 0; m_btu = 0; m_err = 0;
    if (!e) return;
    if (v) begin
      m_idle = 0;
      if (m_cmd.size() == 0) begin
        if (d == "S" || d == "B") m_cmd.push_back(d);
      end else if (char_fits(m_cmd.size(), m_cmd[0], d)) begin
        m_cmd.push_back(d);
        if (m_cmd.size() == 6 + HD) begin
          value = 0;
          for (int i = 6; i < 6 + HD; i++) value = value * 16 + longint'(hex_val(m_cmd[i]));
          if (m_cmd[0] == "S") begin
            m_sw = value[15:0]; m_swu = 1; exp_q.push_back({1'b0, value[15:0]});
          end else begin
            m_bt = value[4:0]; m_btu = 1; exp_q.push_back({1'b1, value[15:0]});
          end
          m_cmd.delete();
        end
      end else begin
        m_err = 1;
        m_cmd.delete();
        if (d == "S" || d == "B") m_cmd.push_back(d);
      end
    end
`ifdef UART_CMD_TIMEOUT_EN
    else if (m_cmd.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_err = 1; m_cmd.delete(); m_idle = 0;
      end
    end
`endif
  endfunction

  function automatic logic [24:0] obs_vec();
    return {switch_data, button_data, switch_update, button_update, parse_error, busy};
  endfunction

  function automatic logic [24:0] exp_vec();
    return {m_sw, m_bt, m_swu, m_btu, m_err, (m_cmd.size() != 0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit e, input bit v, input logic [7:0] d);
    ena = e; rx_valid = v; rx_data = d;
    model_step(e, v, d);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1; ena = 1; rx_valid = 0; rx_data = '0;
    repeat (n) begin @(posedge clk); #1; end
    reset = 0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset(1);
    drive(1, 1, "S"); drive(1, 1, "W");
    do_reset(2);
    checks++;
    if ({switch_data, button_data, switch_update, button_update, parse_error, busy} !== 25'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs_vec());
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_switch_cmd();
    string s = "SW: 0xA5C3";
    int pulses = 0, errs = 0;
    for (int i = 0; i < s.len(); i++) begin
      drive(1, 1, s[i]);
      pulses += int'(switch_update); errs += int'(parse_error);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL switch_cmd byte %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (switch_data !== 16'hA5C3 || switch_update !== 1'b1) begin
      errors++; $display("FAIL switch_value: got %h/%b expected a5c3/1", switch_data, switch_update);
    end
    drive(1, 0, 8'h00);
    pulses += int'(switch_update); errs += int'(parse_error);
    checks++;
    if (pulses != 1 || errs != 0) begin
      errors++; $display("FAIL switch_pulses: got %0d updates %0d errors expected 1/0", pulses, errs);
    end
  endtask

  task automatic test_button_cmd();
    string s = "BT: 0x001F";
    int pulses = 0;
    for (int i = 0; i < s.len(); i++) begin
      drive(1, 1, s[i]);
      pulses += int'(button_update);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL button_cmd byte %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    drive(1, 0, 8'h00);
    checks++;
    if (button_data !== 5'h1F || switch_data !== 16'hA5C3 || pulses != 1) begin
      errors++; $display("FAIL button_value: got bt=%h sw=%h pulses=%0d expected 1f/a5c3/1", button_data, switch_data, pulses);
    end
  endtask

  task automatic test_bad_digit();
    string s = "SW: 0x12G4";
    int upd = 0;
    for (int i = 0; i < s.len(); i++) begin
      drive(1, 1, s[i]);
      upd += int'(switch_update) + int'(button_update);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bad_digit byte %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 8) begin
        checks++;
        if (parse_error !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL bad_digit_error: got err=%b busy=%b expected 1/0", parse_error, busy);
        end
      end
    end
    checks++;
    if (switch_data !== 16'hA5C3 || upd != 0) begin
      errors++; $display("FAIL bad_digit_hold: got sw=%h updates=%0d expected a5c3/0", switch_data, upd);
    end
  endtask

  task automatic test_resync();
    string s = "SW: 0BT: 0x0003";
    int pulses = 0;
    for (int i = 0; i < s.len(); i++) begin
      drive(1, 1, s[i]);
      pulses += int'(button_update);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL resync byte %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if (parse_error !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL resync_error: got err=%b busy=%b expected 1/1", parse_error, busy);
        end
      end
    end
    checks++;
    if (button_data !== 5'h03 || pulses != 1) begin
      errors++; $display("FAIL resync_value: got bt=%h pulses=%0d expected 03/1", button_data, pulses);
    end
  endtask

  task automatic test_ena_gap();
    string a = "SW:";
    string b = " 0xffff";
    string pool = "SB 0x:WT";
    for (int i = 0; i < a.len(); i++) drive(1, 1, a[i]);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, pool.len() - 1)]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL ena_gap cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < b.len(); i++) drive(1, 1, b[i]);
    checks++;
    if (switch_data !== 16'hFFFF || switch_update !== 1'b1) begin
      errors++; $display("FAIL ena_gap_value: got %h/%b expected ffff/1", switch_data, switch_update);
    end
  endtask

  task automatic test_back_to_back();
    string s = "SW: 0x1234BT: 0x0007";
    for (int i = 0; i < s.len(); i++) begin
      drive(1, 1, s[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL back_to_back byte %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (switch_update && button_update) begin
        errors++; $display("FAIL exclusive_updates: got both high expected at most one");
      end
    end
    checks++;
    if (switch_data !== 16'h1234 || button_data !== 5'h07) begin
      errors++; $display("FAIL back_to_back_value: got sw=%h bt=%h expected 1234/07", switch_data, button_data);
    end
  endtask

  task automatic test_random();
    string pool = "SBWTXx: 0123456789abcdefABCDEFG?";
    string hexc = "0123456789abcdefABCDEF";
    byte unsigned bq[$];
    string head;
    logic [16:0] got, want;
    exp_q.delete();
    for (int n = 0; n < 60; n++) begin
      bq.delete();
      head = ($urandom_range(0, 1) == 1) ? "BT: 0" : "SW: 0";
      for (int i = 0; i < head.len(); i++) bq.push_back(head[i]);
      bq.push_back(($urandom_range(0, 1) == 1) ? 8'h78 : 8'h58);
      for (int i = 0; i < HD; i++) bq.push_back(hexc[$urandom_range(0, hexc.len() - 1)]);
      if ($urandom_range(0, 4) == 0) bq[$urandom_range(0, bq.size() - 1)] = pool[$urandom_range(0, pool.len() - 1)];
      foreach (bq[k]) begin
        if ($urandom_range(0, 5) == 0)
          drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) & ~ena, pool[$urandom_range(0, pool.len() - 1)]);
        drive(1, 1, bq[k]);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL random cmd %0d byte %0d: got %h expected %h", n, k, obs_vec(), exp_vec());
        end
        if (switch_update || button_update) begin
          want = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1ffff;
          got  = switch_update ? {1'b0, switch_data} : {1'b1, 11'd0, button_data};
          if (want[16]) want[15:5] = '0;
          checks++;
          if (got !== want) begin
            errors++; $display("FAIL random_scoreboard cmd %0d: got %h expected %h", n, got, want);
          end
        end
      end
    end
    drive(1, 0, 8'h00);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL random_leftover: got %0d pending commits expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    string s = "BT: 0x1";
    for (int i = 0; i < s.len(); i++) drive(1, 1, s[i]);
    do_reset(1);
    checks++;
    if (obs_vec() !== 25'd0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_mid: got %h state %0d expected 0/idle", obs_vec(), dbg_state);
    end
  endtask

`ifdef UART_CMD_TIMEOUT_EN
  task automatic test_timeout();
    string s = "SW: 0x1";
    int seen = -1;
    for (int i = 0; i < s.len(); i++) drive(1, 1, s[i]);
    for (int i = 1; i <= TO + 4; i++) begin
      drive(1, 0, 8'h00);
      if (parse_error && seen < 0) seen = i;
    end
    checks++;
    if (seen != TO || busy !== 1'b0) begin
      errors++; $display("FAIL timeout: got pulse at idle cycle %0d busy=%b expected %0d/0", seen, busy, TO);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1; ena = 0; rx_valid = 0; rx_data = '0;
    model_reset();
    test_reset();
    test_switch_cmd();
    test_button_cmd();
    test_bad_digit();
    test_resync();
    test_ena_gap();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef UART_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
